// File: rtl/regfile_pkg.sv
// Shared register-file types and sizes used by the write-back path.
package regfile_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_idx_t;
    typedef logic [XLEN-1:0]       word_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from the pointer upward with wrap.
// The pointer moves just past the winner whenever a grant is taken.
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] gnt
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] gnt_idx;
    logic             found;
    int               idx;

    // NOTE: every combinational output gets a default before the search loop,
    // so no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N) idx = idx - N;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = PTR_W'(idx);
                found    = 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else if (advance && found) begin
            ptr_q <= (gnt_idx == PTR_W'(N - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register file write port plus the pending-write
// scoreboard the issue stage uses for hazard stalls.
module regfile_wb_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*REG_ADDR_W-1:0] req_rd,
    input  logic [NUM_REQ*XLEN-1:0]       req_data,
    input  logic                          issue_valid,
    input  logic [REG_ADDR_W-1:0]         issue_rd,
    input  logic                          flush,
    output logic                          rf_write_enable,
    output logic [REG_ADDR_W-1:0]         rf_rd,
    output logic [XLEN-1:0]               rf_write_data,
    output logic [31:0]                   busy
);

    import regfile_pkg::*;

    logic [NUM_REQ-1:0]    gnt;
    logic                  any_gnt;
    logic [REG_ADDR_W-1:0] sel_rd;
    logic [XLEN-1:0]       sel_data;
    logic [NUM_REGS-1:0]   busy_q;
    logic [NUM_REGS-1:0]   busy_next;

    // The write port takes one write per cycle, so the arbiter never stalls.
    rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
        .clk     (clk),
        .reset   (reset),
        .req     (req_valid),
        .advance (1'b1),
        .gnt     (gnt)
    );

    assign req_ready = gnt;
    assign any_gnt   = |gnt;

    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_rd   = req_rd[i*REG_ADDR_W +: REG_ADDR_W];
                sel_data = req_data[i*XLEN +: XLEN];
            end
        end
    end

    // Writes to x0 complete the handshake but never raise the write enable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_write_enable <= 1'b0;
            rf_rd           <= '0;
            rf_write_data   <= '0;
        end else begin
            rf_write_enable <= any_gnt && (sel_rd != '0);
            if (any_gnt) begin
                rf_rd         <= sel_rd;
                rf_write_data <= sel_data;
            end
        end
    end

    // Clear on commit, then set on issue so a newer outstanding write wins.
    always_comb begin
        busy_next = flush ? '0 : busy_q;
        if (rf_write_enable) busy_next[rf_rd] = 1'b0;
        if (issue_valid && (issue_rd != '0)) busy_next[issue_rd] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) busy_q <= '0;
        else       busy_q <= busy_next;
    end

    assign busy = busy_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: arbitration table plus scoreboard,
// flush and asynchronous-reset sequences.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [14:0] req_rd;
    logic [95:0] req_data;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        flush;
    logic        rf_write_enable;
    logic [4:0]  rf_rd;
    logic [31:0] rf_write_data;
    logic [31:0] busy;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [2:0]  valid;
        logic [14:0] rd;
        logic [95:0] data;
        logic [2:0]  ready;
        logic        we;
        logic [4:0]  wrd;
        logic [31:0] wdata;
    } vec_t;

    vec_t vecs[12];

    regfile_wb_arbiter #(.NUM_REQ(3), .XLEN(32), .REG_ADDR_W(5)) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_rd          (req_rd),
        .req_data        (req_data),
        .issue_valid     (issue_valid),
        .issue_rd        (issue_rd),
        .flush           (flush),
        .rf_write_enable (rf_write_enable),
        .rf_rd           (rf_rd),
        .rf_write_data   (rf_write_data),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic we, input logic [4:0] rd,
                             input logic [31:0] data);
        check({tag, " we"},   64'(rf_write_enable), 64'(we));
        check({tag, " rd"},   64'(rf_rd),           64'(rd));
        check({tag, " data"}, 64'(rf_write_data),   64'(data));
    endtask

    localparam logic [14:0] RD_A   = {5'd3, 5'd2, 5'd1};
    localparam logic [95:0] DATA_A = {32'hC3, 32'hB2, 32'hA1};
    localparam logic [14:0] RD_B   = {5'd3, 5'd0, 5'd1};
    localparam logic [95:0] DATA_B = {32'hC3, 32'hFFFF_FFFF, 32'hA1};

    initial begin
        vecs[0]  = '{3'b111, RD_A, DATA_A, 3'b001, 1'b0, 5'd0, 32'h0};
        vecs[1]  = '{3'b111, RD_A, DATA_A, 3'b010, 1'b1, 5'd1, 32'hA1};
        vecs[2]  = '{3'b111, RD_A, DATA_A, 3'b100, 1'b1, 5'd2, 32'hB2};
        vecs[3]  = '{3'b111, RD_A, DATA_A, 3'b001, 1'b1, 5'd3, 32'hC3};
        vecs[4]  = '{3'b111, RD_A, DATA_A, 3'b010, 1'b1, 5'd1, 32'hA1};
        vecs[5]  = '{3'b000, RD_A, DATA_A, 3'b000, 1'b1, 5'd2, 32'hB2};
        vecs[6]  = '{3'b010, RD_B, DATA_B, 3'b010, 1'b0, 5'd2, 32'hB2};
        vecs[7]  = '{3'b000, RD_B, DATA_B, 3'b000, 1'b0, 5'd0, 32'hFFFF_FFFF};
        vecs[8]  = '{3'b101, RD_B, DATA_B, 3'b100, 1'b0, 5'd0, 32'hFFFF_FFFF};
        vecs[9]  = '{3'b101, RD_B, DATA_B, 3'b001, 1'b1, 5'd3, 32'hC3};
        vecs[10] = '{3'b000, RD_B, DATA_B, 3'b000, 1'b1, 5'd1, 32'hA1};
        vecs[11] = '{3'b000, RD_B, DATA_B, 3'b000, 1'b0, 5'd1, 32'hA1};

        reset       = 1'b1;
        req_valid   = '0;
        req_rd      = '0;
        req_data    = '0;
        issue_valid = 1'b0;
        issue_rd    = '0;
        flush       = 1'b0;

        #2;
        check_out("reset", 1'b0, 5'd0, 32'h0);
        check("reset ready", 64'(req_ready), 64'(3'b000));
        check("reset busy",  64'(busy),      64'h0);
        step();
        step();
        reset = 1'b0;

        // Round-robin, x0 write suppression and skipped requesters.
        for (int v = 0; v < 12; v++) begin
            req_valid = vecs[v].valid;
            req_rd    = vecs[v].rd;
            req_data  = vecs[v].data;
            #1;
            check($sformatf("vec%0d ready", v), 64'(req_ready), 64'(vecs[v].ready));
            check_out($sformatf("vec%0d", v), vecs[v].we, vecs[v].wrd, vecs[v].wdata);
            check($sformatf("vec%0d busy", v), 64'(busy), 64'h0);
            step();
        end

        // Issue x5, write x5 two cycles later; busy falls two cycles after grant.
        issue_valid = 1'b1; issue_rd = 5'd5;
        step();
        issue_valid = 1'b0;
        check("issue5 set", 64'(busy), 64'h20);
        step();
        req_valid = 3'b001; req_rd = {5'd0, 5'd0, 5'd5}; req_data = {64'h0, 32'h55};
        #1;
        check("issue5 ready", 64'(req_ready), 64'(3'b001));
        check("issue5 busy at grant", 64'(busy), 64'h20);
        step();
        req_valid = 3'b000;
        check_out("wb5", 1'b1, 5'd5, 32'h55);
        check("issue5 busy at write", 64'(busy), 64'h20);
        step();
        check("issue5 cleared", 64'(busy), 64'h0);
        check("wb5 done we", 64'(rf_write_enable), 64'h0);

        // Issue x7 in the same cycle as the x7 write commits: set wins.
        req_valid = 3'b001; req_rd = {5'd0, 5'd0, 5'd7}; req_data = {64'h0, 32'h77};
        #1;
        check("x7 ready", 64'(req_ready), 64'(3'b001));
        step();
        req_valid = 3'b000;
        issue_valid = 1'b1; issue_rd = 5'd7;
        check_out("wb7", 1'b1, 5'd7, 32'h77);
        step();
        issue_valid = 1'b1; issue_rd = 5'd0;
        check("x7 set wins", 64'(busy), 64'h80);
        step();
        issue_valid = 1'b0;
        check("x0 issue ignored", 64'(busy), 64'h80);

        // Build busy=0xF0, then flush with a same-cycle issue and in-flight write.
        for (int r = 4; r <= 6; r++) begin
            issue_valid = 1'b1; issue_rd = 5'(r);
            step();
        end
        issue_valid = 1'b0;
        check("busy F0", 64'(busy), 64'hF0);
        flush = 1'b1; issue_valid = 1'b1; issue_rd = 5'd9;
        req_valid = 3'b001; req_rd = {5'd0, 5'd0, 5'd10}; req_data = {64'h0, 32'hAA};
        step();
        flush = 1'b0; issue_valid = 1'b0; req_valid = 3'b000;
        check("flush busy", 64'(busy), 64'h200);
        check_out("flush wb", 1'b1, 5'd10, 32'hAA);
        step();
        check("post-flush busy", 64'(busy), 64'h200);

        // Asynchronous reset between edges with a write and busy bits in flight.
        req_valid = 3'b010; req_rd = {5'd0, 5'd11, 5'd0}; req_data = {32'h0, 32'hBB, 32'h0};
        issue_valid = 1'b1; issue_rd = 5'd12;
        #1;
        check("pre-reset ready", 64'(req_ready), 64'(3'b010));
        step();
        issue_valid = 1'b0;
        req_valid = 3'b111; req_rd = RD_A; req_data = DATA_A;
        #1;
        check_out("pre-reset", 1'b1, 5'd11, 32'hBB);
        check("pre-reset busy", 64'(busy), 64'h1200);
        check("pre-reset ptr ready", 64'(req_ready), 64'(3'b100));
        #1;
        reset = 1'b1;
        #1;
        check_out("async reset", 1'b0, 5'd0, 32'h0);
        check("async reset busy", 64'(busy), 64'h0);
        check("async reset ready", 64'(req_ready), 64'(3'b001));
        step();
        check("held reset we", 64'(rf_write_enable), 64'h0);
        reset = 1'b0;
        req_valid = 3'b000;
        step();
        check("after reset ready", 64'(req_ready), 64'(3'b000));
        check("after reset we", 64'(rf_write_enable), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
